// File: rtl/cache_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_arbiter
// Description : Round-robin arbiter and sequencer for page refills from the
//               single DDR page-read port into the cache write port.
//               Two requesters (0 = instruction side, 1 = data side) compete
//               for service. The winner's miss address is page-aligned and
//               issued to DDR. The returned page is captured whole and then
//               streamed into the cache one 32-bit word per cycle. A one-cycle
//               done pulse closes the service.
// Ports       : clk, reset (async, active-high)
//               req0_i/addr0_i, req1_i/addr1_i  - refill requests + miss addr
//               gnt0_o/gnt1_o, done0_o/done1_o  - grant level, done pulse
//               busy_o                          - not idle
//               ddr_re_o/ddr_addr_o, ddr_valid_i/ddr_data_i - DDR page read
//               cache_we_o/cache_waddr_o/cache_wdata_o      - cache refill
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_arbiter #(
    parameter int WORDS_PER_PAGE = 128,
    parameter int OFFS_W         = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req0_i,
    input  logic [31:0]                 addr0_i,
    input  logic                        req1_i,
    input  logic [31:0]                 addr1_i,
    output logic                        gnt0_o,
    output logic                        gnt1_o,
    output logic                        done0_o,
    output logic                        done1_o,
    output logic                        busy_o,
    output logic                        ddr_re_o,
    output logic [31:0]                 ddr_addr_o,
    input  logic                        ddr_valid_i,
    input  logic [32*WORDS_PER_PAGE-1:0] ddr_data_i,
    output logic                        cache_we_o,
    output logic [31:0]                 cache_waddr_o,
    output logic [31:0]                 cache_wdata_o
);

    localparam int              CNT_W     = (WORDS_PER_PAGE > 1) ? $clog2(WORDS_PER_PAGE) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_PAGE - 1);
    localparam logic [31:0]     PAGE_MASK = ~((32'd1 << OFFS_W) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DDR_REQ = 2'd1,
        S_FILL    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         done_q, done_d;
    logic               last_q, last_d;     // last served requester (1 = req1)
    logic [31:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               w_page_load;
    logic               w_win;              // winning requester in IDLE
    logic [31:0]        w_sel_addr;
    logic [31:0]        page_q [WORDS_PER_PAGE];

    // A lone requester always wins; on a tie the one not served last wins.
    assign w_win      = (req0_i && req1_i) ? ~last_q : req1_i;
    assign w_sel_addr = w_win ? addr1_i : addr0_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            last_q  <= 1'b1;
            addr_q  <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = 2'b00;
        last_d      = last_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        w_page_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    gnt_d   = w_win ? 2'b10 : 2'b01;
                    addr_d  = w_sel_addr & PAGE_MASK;
                    state_d = S_DDR_REQ;
                end
            end
            S_DDR_REQ: begin
                if (ddr_valid_i) begin
                    w_page_load = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_WORD) begin
                    // Grant drops on the same edge the done pulse rises.
                    cnt_d   = '0;
                    gnt_d   = 2'b00;
                    done_d  = gnt_q;
                    last_d  = gnt_q[1];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Page buffer only loads from DDR_REQ, so stray ddr_valid is ignored.
    for (genvar gi = 0; gi < WORDS_PER_PAGE; gi++) begin : g_word
        always_ff @(posedge clk) begin
            if (w_page_load) begin
                page_q[gi] <= ddr_data_i[32*gi +: 32];
            end
        end
    end

    assign gnt0_o        = gnt_q[0];
    assign gnt1_o        = gnt_q[1];
    assign done0_o       = done_q[0];
    assign done1_o       = done_q[1];
    assign busy_o        = (state_q != S_IDLE);
    assign ddr_re_o      = (state_q == S_DDR_REQ);
    assign ddr_addr_o    = addr_q;
    assign cache_we_o    = (state_q == S_FILL);
    // Write address/data are held at zero outside FILL to keep the bus quiet.
    assign cache_waddr_o = cache_we_o ? (addr_q + {{(30-CNT_W){1'b0}}, cnt_q, 2'b00}) : 32'd0;
    assign cache_wdata_o = cache_we_o ? page_q[cnt_q] : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_refill_arbiter
// Description : Self-checking bench for cache_refill_arbiter. Table of refill
//               services plus hand sequences for async reset mid-fill and
//               continuously held requests. Expected cache writes are queued
//               when the page is driven and popped as the DUT writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_refill_arbiter;

    localparam int WPP = 128;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 req0 = 1'b0, req1 = 1'b0;
    logic [31:0]          addr0 = 32'd0, addr1 = 32'd0;
    logic                 gnt0, gnt1, done0, done1, busy, ddr_re, cache_we;
    logic [31:0]          ddr_addr, cache_waddr, cache_wdata;
    logic                 ddr_valid = 1'b0;
    logic [32*WPP-1:0]    ddr_data = '0;
    logic [32*WPP-1:0]    page;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic        r0;
        logic        r1;
        logic [31:0] a0;
        logic [31:0] a1;
        int          wt;
        logic [31:0] seed;
        logic [1:0]  win;
        logic [31:0] eaddr;
        logic        junk;
    } vec_t;
    vec_t tbl [6];

    cache_refill_arbiter #(.WORDS_PER_PAGE(WPP), .OFFS_W(9)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_i       (req0),
        .addr0_i      (addr0),
        .req1_i       (req1),
        .addr1_i      (addr1),
        .gnt0_o       (gnt0),
        .gnt1_o       (gnt1),
        .done0_o      (done0),
        .done1_o      (done1),
        .busy_o       (busy),
        .ddr_re_o     (ddr_re),
        .ddr_addr_o   (ddr_addr),
        .ddr_valid_i  (ddr_valid),
        .ddr_data_i   (ddr_data),
        .cache_we_o   (cache_we),
        .cache_waddr_o(cache_waddr),
        .cache_wdata_o(cache_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Write monitor and invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (cache_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", cache_waddr, 32'hxxxx_xxxx);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", cache_waddr, e.a);
                check("wr_data", cache_wdata, e.d);
            end
        end
        if (gnt0 && gnt1) check("one_gnt", {gnt1, gnt0}, 32'd1);
        if (cache_we && ddr_re) check("we_re_excl", {cache_we, ddr_re}, 32'd2);
    end

    task automatic drive_page(input logic [31:0] seed, input logic [31:0] eaddr);
        for (int i = 0; i < WPP; i++) begin
            page[32*i +: 32] = seed + i;
            exp_q.push_back('{a: eaddr + 32'(4*i), d: seed + 32'(i)});
        end
        ddr_data  = page;
        ddr_valid = 1'b1;
        tick();
        ddr_valid = 1'b0;
        ddr_data  = ~page;
    endtask

    task automatic serve(input logic r0, input logic r1, input logic [31:0] a0,
                         input logic [31:0] a1, input int wt, input logic [31:0] seed,
                         input logic [1:0] win, input logic [31:0] eaddr,
                         input logic junk, input logic hold);
        int n;
        int c0;
        req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
        n = 0;
        while (!(gnt0 || gnt1) && n < 5) begin
            tick();
            n++;
        end
        check("grant_latency", n, 1);
        if (!(gnt0 || gnt1)) return;
        check("grant_winner", {gnt1, gnt0}, win);
        check("ddr_addr", ddr_addr, eaddr);
        check("req_state", {ddr_re, busy, cache_we}, 3'b110);
        addr0 = ~a0; addr1 = ~a1;
        repeat (wt) tick();
        check("ddr_wait", {ddr_re, busy, cache_we, gnt1, gnt0}, {3'b110, win});
        drive_page(seed, eaddr);
        c0 = cyc;
        check("fill_start", {ddr_re, cache_we}, 2'b01);
        if (!hold) begin
            req0 = 1'b0; req1 = 1'b0;
        end
        if (junk) begin
            repeat (10) tick();
            ddr_valid = 1'b1;
            tick();
            ddr_valid = 1'b0;
        end
        n = 0;
        while (!(done0 || done1) && n < 300) begin
            tick();
            n++;
        end
        check("done_pulse", {done1, done0}, win);
        check("fill_cycles", cyc - c0, WPP);
        check("gnt_at_done", {gnt1, gnt0}, 0);
        check("writes_left", exp_q.size(), 0);
        tick();
        check("done_one_cycle", {done1, done0, busy}, 0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0000_0000,  3, 32'h0000_0000, 2'b01, 32'h0000_1200, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'h8000_0004, 32'h4000_01FF,  0, 32'h0000_1000, 2'b10, 32'h4000_0000, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_0200, 32'hFFFF_FFFF,  1, 32'hA500_0000, 2'b01, 32'h0000_0200, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF,  2, 32'h5A5A_0000, 2'b10, 32'hFFFF_FE00, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'h0000_0000, 32'hABCD_EFFF, 50, 32'h1234_0000, 2'b10, 32'hABCD_EE00, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h1357_9BDF, 32'h0000_0000,  5, 32'hDEAD_0000, 2'b01, 32'h1357_9A00, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_ctrl", {gnt1, gnt0, done1, done0, busy, ddr_re, cache_we}, 0);
        check("rst_ddr_addr", ddr_addr, 0);
        check("rst_waddr", cache_waddr, 0);
        check("rst_wdata", cache_wdata, 0);
        reset = 1'b0;
        tick();

        // ddr_valid while idle is ignored
        ddr_data  = {WPP{32'hBAD0_BAD0}};
        ddr_valid = 1'b1;
        tick();
        ddr_valid = 1'b0;
        check("idle_valid", {busy, ddr_re, cache_we}, 0);

        for (int v = 0; v < 6; v++) begin
            serve(tbl[v].r0, tbl[v].r1, tbl[v].a0, tbl[v].a1, tbl[v].wt, tbl[v].seed,
                  tbl[v].win, tbl[v].eaddr, tbl[v].junk, 1'b0);
        end

        // Reset mid-fill at word 40; pointer was last set to requester 0
        req1 = 1'b1; addr1 = 32'h0000_7777;
        tick();
        check("mr_grant", {gnt1, gnt0}, 2'b10);
        drive_page(32'h7700_0000, 32'h0000_7600);
        req1 = 1'b0;
        repeat (40) tick();
        check("mr_word40", cache_wdata, 32'h7700_0028);
        #1 reset = 1'b1;
        #1;
        check("mr_async_drop", {gnt1, gnt0, busy, ddr_re, cache_we, done1, done0}, 0);
        check("mr_wdata", cache_wdata, 0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Tie after reset goes to 0, then held requests alternate 0,1,0,1
        serve(1'b1, 1'b1, 32'h0000_2468, 32'h0000_1357, 2, 32'h0101_0000, 2'b01, 32'h0000_2400, 1'b0, 1'b1);
        serve(1'b1, 1'b1, 32'h0000_2468, 32'h0000_1357, 0, 32'h0202_0000, 2'b10, 32'h0000_1200, 1'b0, 1'b1);
        serve(1'b1, 1'b1, 32'h0000_2468, 32'h0000_1357, 1, 32'h0303_0000, 2'b01, 32'h0000_2400, 1'b0, 1'b1);
        serve(1'b1, 1'b1, 32'h0000_2468, 32'h0000_1357, 0, 32'h0404_0000, 2'b10, 32'h0000_1200, 1'b0, 1'b1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
        check("final_idle", {busy, gnt1, gnt0}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, %0d vectors applied", n_vec);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
